iloveyou_tx: RTL and testbench
==============================

// Module: iloveyou_tx
// PURPOSE
//  Transmit-side counterpart of the "I Love You" character checker. On a start
//  request it emits the 11-byte ASCII message "I Love You!" one byte per
//  valid/ready transfer, repeated a programmable number of times. Uppercase and
//  lowercase letters are also steered onto cap_flow / low_flow, so the checker
//  input bus can be driven directly.
// PARAMETERS
//  GAP       0  idle cycles (tx_valid low) inserted after each accepted byte
//  REPEAT_W  4  width of repeat_n; max messages per start = 2**REPEAT_W-1
// PORTS
//  clk       in   1         single clock; all logic on posedge
//  rst       in   1         synchronous reset, active-high
//  start     in   1         request; sampled only in IDLE
//  repeat_n  in   REPEAT_W  messages to send, latched with start (0 treated as 1)
//  abort     in   1         synchronous abort, any state
//  tx_ready  in   1         sink ready
//  tx_valid  out  1         byte on tx_data is valid
//  tx_data   out  8         ASCII byte
//  cap_flow  out  8         tx_data if tx_valid and byte in 0x41..0x5A, else 0
//  low_flow  out  8         tx_data if tx_valid and byte in 0x61..0x7A, else 0
//  tx_eom    out  1         high with every '!' byte (end of message)
//  tx_last   out  1         high with the '!' of the final repetition only
//  busy      out  1         high from cycle after start accept until done
//  done      out  1         one-cycle pulse after final byte accepted
// BEHAVIOUR
//  - Message ROM idx 0..10: 49 20 4C 6F 76 65 20 59 6F 75 21 (hex).
//  - Reset (rst=1 at edge): state IDLE; all outputs 0; idx=0; rep count=0.
//  - All outputs registered. FSM: IDLE -> SEND -> (GAP) -> SEND ... -> DONE -> IDLE.
//  - IDLE: start=1 at edge -> latch max(repeat_n,1); next cycle SEND, tx_valid=1,
//    tx_data=0x49, busy=1. Latency start -> first tx_valid = 1 cycle.
//  - SEND: tx_valid held high, tx_data/cap/low/eom/last stable until transfer
//    (tx_valid & tx_ready at edge). tx_ready low stalls indefinitely.
//  - After transfer, GAP=0: next byte presented next cycle (back-to-back).
//    GAP>0: tx_valid=0, outputs zeroed for exactly GAP cycles, then next byte.
//  - idx wraps 10 -> 0 and rep count decrements on each '!' transfer; next
//    message starts at 0x49 with same gap rule; no extra idle between messages.
//  - Final '!' transferred: next cycle DONE: tx_valid=0, busy=0, done=1 (1 cycle);
//    following cycle IDLE. start in SEND/GAP/DONE ignored (not queued).
//  - abort=1 at edge (any non-IDLE state): next cycle IDLE, tx_valid=0, busy=0,
//    done NOT pulsed, idx and count cleared; abort has priority over transfer.
//    abort and start same edge in IDLE: abort wins, no start.
//  - rst has priority over abort/start. Reset mid-message drops tx_valid next cycle.
//  - cap_flow/low_flow: space (0x20) and '!' (0x21) drive both 0.
// TESTING
//  1 rst, start, repeat_n=1, GAP=0, tx_ready=1 -> tx_valid 1 cycle after start,
//    11 consecutive bytes 49 20 4C 6F 76 65 20 59 6F 75 21, tx_last on 0x21, done 1 cycle later.
//  2 tx_ready toggled random -> each byte held stable while stalled; no byte lost/dup.
//  3 repeat_n=3 -> 33 bytes, tx_eom 3 times, tx_last only on 33rd byte, one done pulse.
//  4 repeat_n=0 -> behaves as 1 (11 bytes, one done).
//  5 GAP=2 -> tx_valid low exactly 2 cycles after every transfer; cap_flow=0x4C on
//    'L' byte, low_flow=0x6F on 'o', both 0 on 0x20.
//  6 abort asserted on byte 5 with tx_ready=1 -> tx_valid 0 next cycle, no done; new
//    start then restarts at 0x49. rst mid-message -> all outputs 0 next cycle.

Source files
------------

// File: rtl/iloveyou_tx.sv
// -----------------------------------------------------------------------------
// iloveyou_tx
//
// Transmit side of the "I Love You" character checker. A start request makes
// the block send the 11-byte ASCII message "I Love You!" one byte per
// valid/ready transfer. The message is repeated repeat_n times (0 counts as 1).
// Letters are also steered onto cap_flow / low_flow so that the checker input
// bus can be driven directly from this block.
//
// Parameters
//   GAP       idle cycles (tx_valid low) inserted after every accepted byte
//   REPEAT_W  width of repeat_n; up to 2**REPEAT_W-1 messages per start
//
// Ports
//   clk       in   1         single clock, all logic on posedge
//   rst       in   1         synchronous reset, active-high
//   start     in   1         transmit request, only looked at in IDLE
//   repeat_n  in   REPEAT_W  number of messages, latched together with start
//   abort     in   1         synchronous abort, returns to IDLE without done
//   tx_ready  in   1         sink ready
//   tx_valid  out  1         tx_data holds a valid byte
//   tx_data   out  8         ASCII byte
//   cap_flow  out  8         tx_data when it is an uppercase letter, else 0
//   low_flow  out  8         tx_data when it is a lowercase letter, else 0
//   tx_eom    out  1         marks every '!' byte (end of one message)
//   tx_last   out  1         marks the '!' of the final repetition only
//   busy      out  1         high while a transmission is in progress
//   done      out  1         one-cycle pulse after the final byte is accepted
//
// Every output is a flop. The output flops are loaded from the *next* state,
// index and repeat count, so they always line up with the state register.
// -----------------------------------------------------------------------------
module iloveyou_tx #(
    parameter int GAP      = 0,
    parameter int REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [REPEAT_W-1:0] repeat_n,
    input  logic                abort,
    input  logic                tx_ready,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    output logic [7:0]          cap_flow,
    output logic [7:0]          low_flow,
    output logic                tx_eom,
    output logic                tx_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Gap counter is loaded with GAP-1 and counts down to zero, giving exactly
    // GAP idle cycles. A one-bit counter is kept even when GAP is 0 or 1.
    localparam int                GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam logic [3:0]        LAST_IDX = 4'd10;
    localparam logic [REPEAT_W-1:0] REP_ONE = REPEAT_W'(1);

    // Message ROM: "I Love You!"
    function automatic logic [7:0] msg_rom(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h49;  // I
            4'd1:    b = 8'h20;  // space
            4'd2:    b = 8'h4C;  // L
            4'd3:    b = 8'h6F;  // o
            4'd4:    b = 8'h76;  // v
            4'd5:    b = 8'h65;  // e
            4'd6:    b = 8'h20;  // space
            4'd7:    b = 8'h59;  // Y
            4'd8:    b = 8'h6F;  // o
            4'd9:    b = 8'h75;  // u
            4'd10:   b = 8'h21;  // !
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h5A);
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= 8'h61) && (b <= 8'h7A);
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [REPEAT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic                valid_d;
    logic [7:0]          data_d;
    logic [7:0]          cap_d;
    logic [7:0]          low_d;
    logic                eom_d;
    logic                last_d;
    logic                busy_d;
    logic                done_d;

    logic                end_of_msg;
    logic                final_byte;

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            cap_flow <= '0;
            low_flow <= '0;
            tx_eom   <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            gap_q    <= gap_d;
            tx_valid <= valid_d;
            tx_data  <= data_d;
            cap_flow <= cap_d;
            low_flow <= low_d;
            tx_eom   <= eom_d;
            tx_last  <= last_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    assign end_of_msg = (idx_q == LAST_IDX);
    assign final_byte = end_of_msg && (rep_q == REP_ONE);

    // Next-state logic. Abort outranks everything, including a transfer on
    // the same edge and a start request in IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;

        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            rep_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_SEND;
                        idx_d   = '0;
                        rep_d   = (repeat_n == '0) ? REP_ONE : repeat_n;
                    end
                end

                S_SEND: begin
                    // tx_valid is always high in SEND, so ready alone means
                    // the current byte is transferred at this edge.
                    if (tx_ready) begin
                        if (end_of_msg) begin
                            idx_d = '0;
                            rep_d = rep_q - REP_ONE;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end

                        // The final '!' goes straight to DONE, no gap.
                        if (final_byte) begin
                            state_d = S_DONE;
                        end else if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = S_SEND;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_q == '0) begin
                        state_d = S_SEND;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end

                S_DONE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output logic, evaluated on the next state so the registered outputs
    // show the byte belonging to the state being entered.
    always_comb begin
        valid_d = (state_d == S_SEND);
        data_d  = valid_d ? msg_rom(idx_d) : 8'h00;
        cap_d   = is_upper(data_d) ? data_d : 8'h00;
        low_d   = is_lower(data_d) ? data_d : 8'h00;
        eom_d   = valid_d && (idx_d == LAST_IDX);
        last_d  = eom_d && (rep_d == REP_ONE);
        busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_iloveyou_tx.sv
module tb_iloveyou_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start2;
    logic [3:0] repeat_n;
    logic       abort;
    logic       tx_ready;

    logic       v0, e0, la0, b0, dn0;
    logic [7:0] d0, c0, l0;
    logic       v2, e2, la2, b2, dn2;
    logic [7:0] d2, c2, l2;

    int total = 0;
    int bad   = 0;

    logic [7:0] msg     [11] = '{8'h49, 8'h20, 8'h4C, 8'h6F, 8'h76, 8'h65,
                                 8'h20, 8'h59, 8'h6F, 8'h75, 8'h21};
    logic [7:0] cap_exp [11] = '{8'h49, 8'h00, 8'h4C, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h59, 8'h00, 8'h00, 8'h00};
    logic [7:0] low_exp [11] = '{8'h00, 8'h00, 8'h00, 8'h6F, 8'h76, 8'h65,
                                 8'h00, 8'h00, 8'h6F, 8'h75, 8'h00};

    always #5 clk = ~clk;

    iloveyou_tx #(.GAP(0), .REPEAT_W(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .repeat_n(repeat_n),
        .abort(abort), .tx_ready(tx_ready),
        .tx_valid(v0), .tx_data(d0), .cap_flow(c0), .low_flow(l0),
        .tx_eom(e0), .tx_last(la0), .busy(b0), .done(dn0)
    );

    iloveyou_tx #(.GAP(2), .REPEAT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .repeat_n(repeat_n),
        .abort(abort), .tx_ready(tx_ready),
        .tx_valid(v2), .tx_data(d2), .cap_flow(c2), .low_flow(l2),
        .tx_eom(e2), .tx_last(la2), .busy(b2), .done(dn2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; repeat_n = 4'd1;
        abort = 1'b0; tx_ready = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst valid", v0, 1'b0);
        chk("rst data",  d0, 8'h00);
        chk("rst cap",   c0, 8'h00);
        chk("rst low",   l0, 8'h00);
        chk("rst eom",   e0, 1'b0);
        chk("rst last",  la0, 1'b0);
        chk("rst busy",  b0, 1'b0);
        chk("rst done",  dn0, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle valid", v0, 1'b0);

        // Test 1: single message, back-to-back
        repeat_n = 4'd1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t1 valid[%0d]", i), v0, 1'b1);
            chk($sformatf("t1 data[%0d]", i),  d0, msg[i]);
            chk($sformatf("t1 busy[%0d]", i),  b0, 1'b1);
            chk($sformatf("t1 eom[%0d]", i),   e0, (i == 10));
            chk($sformatf("t1 last[%0d]", i),  la0, (i == 10));
            chk($sformatf("t1 done[%0d]", i),  dn0, 1'b0);
            tick();
        end
        chk("t1 done pulse", dn0, 1'b1);
        chk("t1 done valid", v0, 1'b0);
        chk("t1 done busy",  b0, 1'b0);
        tick();
        chk("t1 done clear", dn0, 1'b0);
        chk("t1 idle busy",  b0, 1'b0);

        // Test 2: stalls of 0..2 cycles per byte
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t2 data[%0d]", i), d0, msg[i]);
            for (int s = 0; s < (i % 3) + ((i == 4) ? 1 : 0); s++) begin
                tx_ready = 1'b0;
                tick();
                chk($sformatf("t2 hold valid[%0d.%0d]", i, s), v0, 1'b1);
                chk($sformatf("t2 hold data[%0d.%0d]", i, s),  d0, msg[i]);
                chk($sformatf("t2 hold last[%0d.%0d]", i, s),  la0, (i == 10));
            end
            tx_ready = 1'b1;
            tick();
        end
        chk("t2 done pulse", dn0, 1'b1);
        tick();
        chk("t2 done clear", dn0, 1'b0);

        // Test 3: three repetitions
        repeat_n = 4'd3; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 33; i++) begin
            chk($sformatf("t3 valid[%0d]", i), v0, 1'b1);
            chk($sformatf("t3 data[%0d]", i),  d0, msg[i % 11]);
            chk($sformatf("t3 eom[%0d]", i),   e0, ((i % 11) == 10));
            chk($sformatf("t3 last[%0d]", i),  la0, (i == 32));
            chk($sformatf("t3 done[%0d]", i),  dn0, 1'b0);
            tick();
        end
        chk("t3 done pulse", dn0, 1'b1);
        tick();
        chk("t3 done clear", dn0, 1'b0);
        chk("t3 idle valid", v0, 1'b0);

        // Test 4: repeat_n = 0 behaves as 1
        repeat_n = 4'd0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t4 data[%0d]", i), d0, msg[i]);
            chk($sformatf("t4 last[%0d]", i), la0, (i == 10));
            tick();
        end
        chk("t4 done pulse", dn0, 1'b1);
        chk("t4 valid after", v0, 1'b0);
        tick();
        chk("t4 done clear", dn0, 1'b0);

        // Test 5: GAP=2 instance, letter steering
        repeat_n = 4'd1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t5 valid[%0d]", i), v2, 1'b1);
            chk($sformatf("t5 data[%0d]", i),  d2, msg[i]);
            chk($sformatf("t5 cap[%0d]", i),   c2, cap_exp[i]);
            chk($sformatf("t5 low[%0d]", i),   l2, low_exp[i]);
            tick();
            if (i < 10) begin
                chk($sformatf("t5 gap1 valid[%0d]", i), v2, 1'b0);
                chk($sformatf("t5 gap1 data[%0d]", i),  d2, 8'h00);
                chk($sformatf("t5 gap1 busy[%0d]", i),  b2, 1'b1);
                tick();
                chk($sformatf("t5 gap2 valid[%0d]", i), v2, 1'b0);
                chk($sformatf("t5 gap2 cap[%0d]", i),   c2, 8'h00);
                tick();
            end
        end
        chk("t5 done pulse", dn2, 1'b1);
        chk("t5 done valid", v2, 1'b0);
        tick();
        chk("t5 done clear", dn2, 1'b0);

        // Test 6: abort on byte 5 with tx_ready high
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6 byte5 data", d0, 8'h76);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6 abort valid", v0, 1'b0);
        chk("t6 abort busy",  b0, 1'b0);
        chk("t6 abort done",  dn0, 1'b0);
        chk("t6 abort data",  d0, 8'h00);
        tick();
        chk("t6 abort no done", dn0, 1'b0);
        chk("t6 abort idle",    v0, 1'b0);

        // Restart begins at the first byte
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("t6 restart data", d0, 8'h49);
        chk("t6 restart busy", b0, 1'b1);
        tick(); tick();
        chk("t6 restart byte3", d0, 8'h4C);
        chk("t6 restart cap",   c0, 8'h4C);

        // Reset mid-message
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 rst valid", v0, 1'b0);
        chk("t6 rst data",  d0, 8'h00);
        chk("t6 rst cap",   c0, 8'h00);
        chk("t6 rst busy",  b0, 1'b0);
        chk("t6 rst done",  dn0, 1'b0);

        // Abort and start on the same edge in IDLE: abort wins
        start0 = 1'b1; abort = 1'b1;
        tick();
        start0 = 1'b0; abort = 1'b0;
        chk("t6 abort+start valid", v0, 1'b0);
        chk("t6 abort+start busy",  b0, 1'b0);
        tick();
        chk("t6 abort+start stay", v0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
